// File: rtl/loader_pkg.sv
// Shared types for the boot-time instruction loader: FSM state encoding and
// default status bytes. Optional checksum stage: LOADER_CHECKSUM_EN.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_SUM,
    S_ACK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] DEF_ACK_BYTE = 8'hAA;
  localparam logic [7:0] DEF_NAK_BYTE = 8'h55;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_done flags the
// 4th byte of each word in the same cycle the byte arrives.
module byte_packer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  cnt;
  logic [23:0] sh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      sh  <= '0;
    end else if (clr) begin
      cnt <= '0;
      sh  <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + 2'd1;
      sh  <= {byte_data, sh[23:8]};
    end
  end

  // The 4th byte bypasses the shift register so the word is ready immediately.
  assign word      = {byte_data, sh};
  assign word_done = byte_valid && !clr && (cnt == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Boot loader: length-prefixed byte stream -> word writes to instruction memory,
// then a one-byte ACK/NAK status. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module inst_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 16384,
  parameter logic [7:0]  ACK_BYTE  = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE  = DEF_NAK_BYTE
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        loaded,
  output logic        error
);

  state_t      state, state_d;
  logic        ack_q, ack_d;
  logic [1:0]  len_cnt;
  logic [23:0] len_sh;
  logic [31:0] len_word;
  logic [31:0] n_q;
  logic [31:0] word_idx;
  logic        len_done;
  logic        pk_valid;
  logic [31:0] pk_word;
  logic        word_done;
  logic        last_word;
  logic        hs;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign len_word  = {rx_data, len_sh};
  assign len_done  = (state == S_LEN) && rx_valid && (len_cnt == 2'd3);
  assign pk_valid  = (state == S_DATA) && rx_valid;
  assign last_word = word_done && ((word_idx + 32'd1) == n_q);
  assign hs        = (state == S_ACK) && tx_valid && tx_ready;

  byte_packer u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (len_done),
    .byte_valid (pk_valid),
    .byte_data  (rx_data),
    .word       (pk_word),
    .word_done  (word_done)
  );

  always_comb begin
    state_d = state;
    ack_d   = ack_q;
    case (state)
      S_LEN: begin
        if (len_done) begin
          if (len_word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_SUM;
`else
            state_d = S_ACK;
            ack_d   = 1'b1;
`endif
          end else if (len_word > MAX_WORDS) begin
            state_d = S_ACK;
            ack_d   = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_SUM;
`else
          state_d = S_ACK;
          ack_d   = 1'b1;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_SUM: begin
        if (rx_valid) begin
          state_d = S_ACK;
          ack_d   = (rx_data == csum);
        end
      end
`endif
      S_ACK: begin
        if (hs) state_d = ack_q ? S_DONE : S_ERR;
      end
      default: state_d = state;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_LEN;
      ack_q     <= 1'b0;
      len_cnt   <= '0;
      len_sh    <= '0;
      n_q       <= '0;
      word_idx  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      state  <= state_d;
      ack_q  <= ack_d;
      mem_we <= word_done;
      if ((state == S_LEN) && rx_valid) begin
        len_cnt <= len_cnt + 2'd1;
        len_sh  <= {rx_data, len_sh[23:8]};
      end
      if (len_done) begin
        n_q      <= len_word;
        word_idx <= '0;
      end
      if (word_done) begin
        mem_wdata <= pk_word;
        mem_addr  <= word_idx << 2;
        word_idx  <= word_idx + 32'd1;
      end
      // Registered one cycle after entering S_ACK so it never overlaps the last write.
      tx_valid <= (state == S_ACK) && !hs;
      if ((state == S_ACK) && !tx_valid) tx_data <= ack_q ? ACK_BYTE : NAK_BYTE;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         csum <= '0;
    else if (len_done) csum <= '0;
    else if (pk_valid) csum <= csum ^ rx_data;
  end
`endif

  assign loaded = (state == S_DONE);
  assign error  = (state == S_ERR);

endmodule

// File: tb/tb_inst_loader.sv
// Directed table-driven bench for inst_loader, plus reset-mid-load sequences.
module tb_inst_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        loaded;
  logic        error;

  always #5 clk = ~clk;

  inst_loader #(
    .MAX_WORDS (4),
    .ACK_BYTE  (8'hAA),
    .NAK_BYTE  (8'h55)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .loaded    (loaded),
    .error     (error)
  );

  typedef struct {
    int unsigned  nbytes;
    logic [191:0] b;       // stream bytes, first byte most significant
    int unsigned  nwr;
    logic [127:0] wd;      // expected word i at [32*i +: 32]
    logic [7:0]   txb;
    logic         ok;
    logic         exact;   // last byte is the one that ends the load
    int unsigned  stall;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  int unsigned nw = 0;
  int unsigned overlap = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      if (nw < 8) begin
        wr_addr[nw] = mem_addr;
        wr_data[nw] = mem_wdata;
      end
      nw++;
    end
    if ((mem_we && tx_valid) || (mem_we && prev_we)) overlap++;
    prev_we = mem_we;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input int idx, input string what, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec%0d %s: got %h, expected %h", idx, what, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input vec_t v, input int unsigned i);
    return v.b[8*(v.nbytes-1-i) +: 8];
  endfunction

  function automatic void add(input int unsigned nb, input logic [191:0] b, input bit use_cs,
                              input logic [7:0] cs, input int unsigned nwr, input logic [127:0] wd,
                              input logic [7:0] txb, input logic ok, input logic exact,
                              input int unsigned stall);
    vec_t v;
    v.nbytes = nb;
    v.b      = b;
    if (CS_EN && use_cs) begin
      v.b      = (b << 8) | {184'd0, cs};
      v.nbytes = nb + 1;
    end
    v.nwr   = nwr;
    v.wd    = wd;
    v.txb   = txb;
    v.ok    = ok;
    v.exact = exact;
    v.stall = stall;
    vecs.push_back(v);
  endfunction

  task automatic run_vec(input int idx, input int unsigned pre);
    vec_t v;
    vec_t p;
    int unsigned cyc;
    logic stable;
    v = vecs[idx];
    p = vecs[0];
    if (pre > 0) begin
      rstn = 1'b0; tick(); rstn = 1'b1; tick();
      for (int unsigned i = 0; i < pre; i++) begin
        rx_valid = 1'b1; rx_data = byte_at(p, i); tick();
      end
      rx_valid = 1'b0; tick();
    end
    rstn = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    tick();
    check(idx, "reset", {tx_valid, tx_data, mem_addr, mem_wdata, mem_we, loaded, error},
          96'd0);
    nw = 0; overlap = 0; prev_we = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    for (int unsigned i = 0; i < v.nbytes; i++) begin
      rx_valid = 1'b1; rx_data = byte_at(v, i); tick();
    end
    rx_valid = 1'b0;
    if (v.exact) check(idx, "tx_early", {95'd0, tx_valid}, 96'd0);
    cyc = 0;
    while (!tx_valid && cyc < 64) begin
      tick();
      cyc++;
    end
    check(idx, "tx_valid", {95'd0, tx_valid}, 96'd1);
    if (v.exact) check(idx, "tx_latency", {64'd0, cyc}, 96'd1);
    check(idx, "tx_data", {88'd0, tx_data}, {88'd0, v.txb});
    stable = 1'b1;
    for (int unsigned s = 0; s < v.stall; s++) begin
      tick();
      if (!(tx_valid && tx_data == v.txb && !loaded && !error)) stable = 1'b0;
    end
    if (v.stall > 0) check(idx, "stall_stable", {95'd0, stable}, 96'd1);
    check(idx, "pre_handshake", {94'd0, loaded, error}, 96'd0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check(idx, "post_handshake", {93'd0, tx_valid, loaded, error}, {93'd0, 1'b0, v.ok, !v.ok});
    check(idx, "write_count", {64'd0, nw}, {64'd0, v.nwr});
    for (int unsigned i = 0; i < v.nwr && i < 8; i++)
      check(idx, $sformatf("write%0d", i), {32'd0, wr_addr[i], wr_data[i]},
            {32'd0, i * 32'd4, v.wd[32*i +: 32]});
    for (int unsigned i = 0; i < 8; i++) begin
      rx_valid = 1'b1; rx_data = (i == 0) ? 8'h01 : 8'(i); tick();
    end
    rx_valid = 1'b0;
    repeat (4) tick();
    check(idx, "terminal", {61'd0, tx_valid, loaded, error, nw},
          {61'd0, 1'b0, v.ok, !v.ok, v.nwr});
    check(idx, "we_overlap", {64'd0, overlap}, 96'd0);
  endtask

  initial begin
    add(12, {8'h02,8'h00,8'h00,8'h00, 8'h13,8'h00,8'h00,8'h00, 8'h6F,8'h00,8'h00,8'h00},
        1'b1, 8'h7C, 2, 128'h0000006F_00000013, 8'hAA, 1'b1, 1'b1, 0);
    add(4, {8'h00,8'h00,8'h00,8'h00}, 1'b1, 8'h00, 0, '0, 8'hAA, 1'b1, 1'b1, 0);
    add(8, {8'h01,8'h40,8'h00,8'h00, 8'hDE,8'hAD,8'hBE,8'hEF},
        1'b0, 8'h00, 0, '0, 8'h55, 1'b0, 1'b0, 0);
    add(8, {8'h01,8'h00,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44},
        1'b1, 8'h44, 1, 128'h44332211, 8'hAA, 1'b1, 1'b1, 10);
    add(20, {8'h04,8'h00,8'h00,8'h00, 8'h10,8'h11,8'h12,8'h13, 8'h20,8'h21,8'h22,8'h23,
             8'h30,8'h31,8'h32,8'h33, 8'h40,8'h41,8'h42,8'h43},
        1'b1, 8'h00, 4, 128'h43424140_33323130_23222120_13121110, 8'hAA, 1'b1, 1'b1, 0);
    add(4, {8'h05,8'h00,8'h00,8'h00}, 1'b0, 8'h00, 0, '0, 8'h55, 1'b0, 1'b1, 0);
    add(4, {8'hFF,8'hFF,8'hFF,8'hFF}, 1'b0, 8'h00, 0, '0, 8'h55, 1'b0, 1'b1, 0);
    if (CS_EN) begin
      add(8, {8'h01,8'h00,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44},
          1'b1, 8'h45, 1, 128'h44332211, 8'h55, 1'b0, 1'b1, 0);
      add(4, {8'h00,8'h00,8'h00,8'h00}, 1'b1, 8'h01, 0, '0, 8'h55, 1'b0, 1'b1, 0);
    end

    for (int i = 0; i < vecs.size(); i++) run_vec(i, 0);
    run_vec(0, 6);
    run_vec(0, 9);
    run_vec(3, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
